hazard_stall_unit: RTL and testbench

- Pipeline interlock controller for the 5-stage RV32 core. It is the stall-side counterpart to the EX-stage bypass logic.
- It detects hazards that bypassing cannot resolve: load-use RAW, RAW on a pending multi-cycle MDU (mul/div) result, and MDU structural conflicts. It also handles taken-branch flushes.
- It drives the IF/ID hold, ID/EX bubble and ID flush controls, and owns the single-MDU occupancy FSM and its latency counter.

---
 rtl/hazard_stall_unit_if.sv | 53 +++++
 rtl/hazard_stall_unit.sv | 119 +++++++++++
 tb/tb_hazard_stall_unit.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_stall_unit_if.sv
// ============================================================================
// hazard_stall_unit_if : operand/hazard/stall bundle between pipeline and
//                        hazard_stall_unit (perf outputs under HAZARD_PERF_CNT_EN)
// Revision : 1.0
// ============================================================================
`default_nettype none

interface hazard_stall_unit_if #(
  parameter int RF_LOGSIZE = 5
);
  logic [RF_LOGSIZE-1:0] rs1_id;
  logic [RF_LOGSIZE-1:0] rs2_id;
  logic                  use_rs1_id;
  logic                  use_rs2_id;
  logic                  mdu_op_id;
  logic                  memrd_ex;
  logic [RF_LOGSIZE-1:0] rd_ex;
  logic                  mdu_issue_ex;
  logic                  branch_taken_ex;
  logic                  pc_stall;
  logic                  id_stall;
  logic                  ex_bubble;
  logic                  id_flush;
  logic                  mdu_busy;
  logic                  mdu_wb_valid;
  logic [RF_LOGSIZE-1:0] mdu_wb_rd;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0]           stall_cycles;
  logic [31:0]           flush_cycles;
`endif

  modport master (
    output rs1_id, rs2_id, use_rs1_id, use_rs2_id, mdu_op_id,
    output memrd_ex, rd_ex, mdu_issue_ex, branch_taken_ex,
`ifdef HAZARD_PERF_CNT_EN
    input  stall_cycles, flush_cycles,
`endif
    input  pc_stall, id_stall, ex_bubble, id_flush,
    input  mdu_busy, mdu_wb_valid, mdu_wb_rd
  );

  modport slave (
    input  rs1_id, rs2_id, use_rs1_id, use_rs2_id, mdu_op_id,
    input  memrd_ex, rd_ex, mdu_issue_ex, branch_taken_ex,
`ifdef HAZARD_PERF_CNT_EN
    output stall_cycles, flush_cycles,
`endif
    output pc_stall, id_stall, ex_bubble, id_flush,
    output mdu_busy, mdu_wb_valid, mdu_wb_rd
  );
endinterface

`default_nettype wire

// File: rtl/hazard_stall_unit.sv
// ============================================================================
// hazard_stall_unit : load-use / MDU RAW / MDU structural interlock, branch
//                     flush and single-MDU occupancy FSM.
//                     Optional perf counters: define HAZARD_PERF_CNT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module hazard_stall_unit #(
  parameter int MDU_LAT    = 4,
  parameter int RF_LOGSIZE = 5
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  hazard_stall_unit_if.slave bus
);

  localparam logic [3:0] CNT_LOAD = 4'(MDU_LAT - 1);

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t                state, state_nxt;
  logic [3:0]            cnt, cnt_nxt;
  logic [RF_LOGSIZE-1:0] pend_rd, pend_rd_nxt;
  logic                  wb_valid;

  logic busy;
  logic load_use;
  logic mdu_raw;
  logic mdu_struct;
  logic stall;
  logic flush;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_RUN;
      cnt     <= '0;
      pend_rd <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      pend_rd <= pend_rd_nxt;
    end
  end

  // Issues seen while BUSY are ignored; the pipeline should have stalled them.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    pend_rd_nxt = pend_rd;
    wb_valid    = 1'b0;
    case (state)
      ST_RUN: begin
        if (bus.mdu_issue_ex) begin
          state_nxt   = ST_BUSY;
          cnt_nxt     = CNT_LOAD;
          pend_rd_nxt = bus.rd_ex;
        end
      end
      ST_BUSY: begin
        if (cnt == 4'd0) begin
          wb_valid  = 1'b1;
          state_nxt = ST_RUN;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  assign busy = (state == ST_BUSY);

  assign load_use = bus.memrd_ex && (bus.rd_ex != '0) &&
                    ((bus.use_rs1_id && (bus.rs1_id == bus.rd_ex)) ||
                     (bus.use_rs2_id && (bus.rs2_id == bus.rd_ex)));

  assign mdu_raw = busy && (pend_rd != '0) &&
                   ((bus.use_rs1_id && (bus.rs1_id == pend_rd)) ||
                    (bus.use_rs2_id && (bus.rs2_id == pend_rd)));

  assign mdu_struct = bus.mdu_op_id && (busy || bus.mdu_issue_ex);

  assign stall = load_use || mdu_raw || mdu_struct;
  assign flush = bus.branch_taken_ex;

  // A taken branch kills the ID instruction, so its hazard no longer matters.
  assign bus.pc_stall     = stall && !flush;
  assign bus.id_stall     = stall && !flush;
  assign bus.ex_bubble    = stall || flush;
  assign bus.id_flush     = flush;
  assign bus.mdu_busy     = busy;
  assign bus.mdu_wb_valid = wb_valid;
  assign bus.mdu_wb_rd    = wb_valid ? pend_rd : '0;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (bus.pc_stall) stall_cnt <= stall_cnt + 32'd1;
      if (bus.id_flush) flush_cnt <= flush_cnt + 32'd1;
    end
  end

  assign bus.stall_cycles = stall_cnt;
  assign bus.flush_cycles = flush_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_stall_unit.sv
// ============================================================================
// tb_hazard_stall_unit : directed self-checking bench for hazard_stall_unit
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_hazard_stall_unit;

  localparam int MDU_LAT    = 4;
  localparam int RF_LOGSIZE = 5;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fails;

  hazard_stall_unit_if #(.RF_LOGSIZE(RF_LOGSIZE)) bus ();

  hazard_stall_unit #(
    .MDU_LAT    (MDU_LAT),
    .RF_LOGSIZE (RF_LOGSIZE)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // {pc_stall, id_stall, ex_bubble, id_flush}
  logic [3:0] ctl;
  assign ctl = {bus.pc_stall, bus.id_stall, bus.ex_bubble, bus.id_flush};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t required < 200000", $time);
    $fatal(1);
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.rs1_id          = '0;
    bus.rs2_id          = '0;
    bus.use_rs1_id      = 1'b0;
    bus.use_rs2_id      = 1'b0;
    bus.mdu_op_id       = 1'b0;
    bus.memrd_ex        = 1'b0;
    bus.rd_ex           = '0;
    bus.mdu_issue_ex    = 1'b0;
    bus.branch_taken_ex = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (ctl !== 4'b0000) begin
      n_fails++; $display("FAIL reset_ctl: got %b expected 0000", ctl);
    end
    n_checks++;
    if ({bus.mdu_busy, bus.mdu_wb_valid, bus.mdu_wb_rd} !== 7'd0) begin
      n_fails++; $display("FAIL reset_mdu: busy=%b wbv=%b wbrd=%0d expected all 0",
                          bus.mdu_busy, bus.mdu_wb_valid, bus.mdu_wb_rd);
    end
`ifdef HAZARD_PERF_CNT_EN
    n_checks++;
    if ({bus.stall_cycles, bus.flush_cycles} !== 64'd0) begin
      n_fails++; $display("FAIL reset_perf: stall=%0d flush=%0d expected 0",
                          bus.stall_cycles, bus.flush_cycles);
    end
`endif
  endtask

  task automatic test_load_use();
    next_cycle();
    clear_inputs();
    bus.memrd_ex = 1'b1; bus.rd_ex = 5'd5; bus.rs1_id = 5'd5; bus.use_rs1_id = 1'b1;
    @(negedge clk);
    n_checks++;
    if (ctl !== 4'b1110) begin
      n_fails++; $display("FAIL load_use_rs1: got %b expected 1110", ctl);
    end
    next_cycle();
    clear_inputs();
    bus.rs1_id = 5'd5; bus.use_rs1_id = 1'b1;
    @(negedge clk);
    n_checks++;
    if (ctl !== 4'b0000) begin
      n_fails++; $display("FAIL load_use_release: got %b expected 0000", ctl);
    end
    next_cycle();
    clear_inputs();
    bus.memrd_ex = 1'b1; bus.rd_ex = 5'd0; bus.rs1_id = 5'd0; bus.use_rs1_id = 1'b1;
    @(negedge clk);
    n_checks++;
    if (ctl !== 4'b0000) begin
      n_fails++; $display("FAIL load_use_x0: got %b expected 0000", ctl);
    end
    next_cycle();
    clear_inputs();
    bus.memrd_ex = 1'b1; bus.rd_ex = 5'd9; bus.rs2_id = 5'd9; bus.use_rs2_id = 1'b1;
    @(negedge clk);
    n_checks++;
    if (ctl !== 4'b1110) begin
      n_fails++; $display("FAIL load_use_rs2: got %b expected 1110", ctl);
    end
    next_cycle();
    clear_inputs();
    bus.memrd_ex = 1'b1; bus.rd_ex = 5'd9; bus.rs1_id = 5'd9; bus.rs2_id = 5'd9;
    @(negedge clk);
    n_checks++;
    if (ctl !== 4'b0000) begin
      n_fails++; $display("FAIL load_use_unused: got %b expected 0000", ctl);
    end
  endtask

  task automatic test_mdu_raw();
    next_cycle();
    clear_inputs();
    bus.mdu_issue_ex = 1'b1; bus.rd_ex = 5'd7;
    @(negedge clk);
    n_checks++;
    if ({bus.mdu_busy, ctl} !== 5'b0_0000) begin
      n_fails++; $display("FAIL mdu_raw_c0: busy=%b ctl=%b expected 0/0000", bus.mdu_busy, ctl);
    end
    for (int c = 1; c <= 5; c++) begin
      next_cycle();
      clear_inputs();
      bus.rs1_id = 5'd7; bus.use_rs1_id = 1'b1;
      @(negedge clk);
      n_checks++;
      if (bus.mdu_busy !== (c <= 4)) begin
        n_fails++; $display("FAIL mdu_raw_busy c%0d: got %b expected %b", c, bus.mdu_busy, (c <= 4));
      end
      n_checks++;
      if (bus.mdu_wb_valid !== (c == 4)) begin
        n_fails++; $display("FAIL mdu_raw_wbv c%0d: got %b expected %b", c, bus.mdu_wb_valid, (c == 4));
      end
      n_checks++;
      if (ctl !== ((c <= 4) ? 4'b1110 : 4'b0000)) begin
        n_fails++; $display("FAIL mdu_raw_ctl c%0d: got %b expected %b", c, ctl,
                            (c <= 4) ? 4'b1110 : 4'b0000);
      end
      if (c == 4) begin
        n_checks++;
        if (bus.mdu_wb_rd !== 5'd7) begin
          n_fails++; $display("FAIL mdu_raw_wbrd: got %0d expected 7", bus.mdu_wb_rd);
        end
      end
    end
  endtask

  task automatic test_mdu_x0();
    next_cycle();
    clear_inputs();
    bus.mdu_issue_ex = 1'b1; bus.rd_ex = 5'd0;
    @(negedge clk);
    for (int c = 1; c <= 5; c++) begin
      next_cycle();
      clear_inputs();
      bus.rs1_id = 5'd0; bus.use_rs1_id = 1'b1; bus.rs2_id = 5'd0; bus.use_rs2_id = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({bus.mdu_busy, bus.mdu_wb_valid, ctl} !== {(c <= 4), (c == 4), 4'b0000}) begin
        n_fails++; $display("FAIL mdu_x0 c%0d: busy=%b wbv=%b ctl=%b expected %b/%b/0000",
                            c, bus.mdu_busy, bus.mdu_wb_valid, ctl, (c <= 4), (c == 4));
      end
    end
  endtask

  task automatic test_struct();
    next_cycle();
    clear_inputs();
    bus.mdu_issue_ex = 1'b1; bus.rd_ex = 5'd3; bus.mdu_op_id = 1'b1;
    @(negedge clk);
    n_checks++;
    if (ctl !== 4'b1110) begin
      n_fails++; $display("FAIL struct_c0: got %b expected 1110", ctl);
    end
    for (int c = 1; c <= 4; c++) begin
      next_cycle();
      clear_inputs();
      bus.mdu_op_id = 1'b1;
      if (c == 2) begin
        bus.mdu_issue_ex = 1'b1; bus.rd_ex = 5'd9;
      end
      @(negedge clk);
      n_checks++;
      if ({bus.mdu_busy, ctl} !== 5'b1_1110) begin
        n_fails++; $display("FAIL struct_busy c%0d: busy=%b ctl=%b expected 1/1110", c, bus.mdu_busy, ctl);
      end
      if (c == 4) begin
        n_checks++;
        if ({bus.mdu_wb_valid, bus.mdu_wb_rd} !== {1'b1, 5'd3}) begin
          n_fails++; $display("FAIL struct_ignore_issue: wbv=%b wbrd=%0d expected 1/3",
                              bus.mdu_wb_valid, bus.mdu_wb_rd);
        end
      end
    end
    next_cycle();
    clear_inputs();
    bus.mdu_issue_ex = 1'b1; bus.rd_ex = 5'd4;
    @(negedge clk);
    n_checks++;
    if ({bus.mdu_busy, ctl} !== 5'b0_0000) begin
      n_fails++; $display("FAIL struct_c5: busy=%b ctl=%b expected 0/0000", bus.mdu_busy, ctl);
    end
    for (int c = 6; c <= 10; c++) begin
      next_cycle();
      clear_inputs();
      @(negedge clk);
      n_checks++;
      if ({bus.mdu_busy, bus.mdu_wb_valid} !== {(c <= 9), (c == 9)}) begin
        n_fails++; $display("FAIL struct_second c%0d: busy=%b wbv=%b expected %b/%b",
                            c, bus.mdu_busy, bus.mdu_wb_valid, (c <= 9), (c == 9));
      end
      if (c == 9) begin
        n_checks++;
        if (bus.mdu_wb_rd !== 5'd4) begin
          n_fails++; $display("FAIL struct_second_wbrd: got %0d expected 4", bus.mdu_wb_rd);
        end
      end
    end
  endtask

  task automatic test_flush();
    next_cycle();
    clear_inputs();
    bus.memrd_ex = 1'b1; bus.rd_ex = 5'd5; bus.rs1_id = 5'd5; bus.use_rs1_id = 1'b1;
    bus.branch_taken_ex = 1'b1;
    @(negedge clk);
    n_checks++;
    if (ctl !== 4'b0011) begin
      n_fails++; $display("FAIL flush_priority: got %b expected 0011", ctl);
    end
    next_cycle();
    clear_inputs();
    bus.mdu_issue_ex = 1'b1; bus.rd_ex = 5'd7;
    @(negedge clk);
    for (int c = 1; c <= 5; c++) begin
      next_cycle();
      clear_inputs();
      if (c == 1) begin
        bus.branch_taken_ex = 1'b1; bus.rs1_id = 5'd7; bus.use_rs1_id = 1'b1; bus.mdu_op_id = 1'b1;
      end
      @(negedge clk);
      n_checks++;
      if ({bus.mdu_busy, bus.mdu_wb_valid, ctl} !==
          {(c <= 4), (c == 4), (c == 1) ? 4'b0011 : 4'b0000}) begin
        n_fails++; $display("FAIL flush_mdu c%0d: busy=%b wbv=%b ctl=%b", c,
                            bus.mdu_busy, bus.mdu_wb_valid, ctl);
      end
    end
  endtask

  task automatic test_reset_mid_op();
    next_cycle();
    clear_inputs();
    bus.mdu_issue_ex = 1'b1; bus.rd_ex = 5'd6;
    @(negedge clk);
    next_cycle();
    clear_inputs();
    bus.rs1_id = 5'd6; bus.use_rs1_id = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({bus.mdu_busy, ctl} !== 5'b1_1110) begin
      n_fails++; $display("FAIL rst_mid_c1: busy=%b ctl=%b expected 1/1110", bus.mdu_busy, ctl);
    end
    next_cycle();
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.mdu_wb_valid !== 1'b0) begin
      n_fails++; $display("FAIL rst_mid_c2_wbv: got %b expected 0", bus.mdu_wb_valid);
    end
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({bus.mdu_busy, bus.mdu_wb_valid, ctl} !== 6'b00_0000) begin
      n_fails++; $display("FAIL rst_mid_c3: busy=%b wbv=%b ctl=%b expected 0/0/0000",
                          bus.mdu_busy, bus.mdu_wb_valid, ctl);
    end
`ifdef HAZARD_PERF_CNT_EN
    n_checks++;
    if (bus.stall_cycles !== 32'd0) begin
      n_fails++; $display("FAIL rst_mid_perf: stall_cycles=%0d expected 0", bus.stall_cycles);
    end
`endif
    for (int c = 4; c <= 7; c++) begin
      next_cycle();
      @(negedge clk);
      n_checks++;
      if ({bus.mdu_busy, bus.mdu_wb_valid} !== 2'b00) begin
        n_fails++; $display("FAIL rst_mid_c%0d: busy=%b wbv=%b expected 0/0",
                            c, bus.mdu_busy, bus.mdu_wb_valid);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    test_reset();
    test_load_use();
    test_mdu_raw();
    test_mdu_x0();
    test_struct();
    test_flush();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

`default_nettype wire
